stream_demux: RTL and testbench

//  1:N packet demultiplexer. Single input stream, valid/ready handshake, packet-framed.
//  - Each packet goes to one of N output channels; the channel is chosen by sel on the first beat.
//  - One registered output stage; channel switches only at packet boundaries.
//  - Used wherever a shared stream fans out to multiple consumers.

---
 rtl/stream_demux.sv | 190 +++++++++++++++++++
 tb/tb_stream_demux.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux.sv
// -----------------------------------------------------------------------------
// stream_demux
//
// 1:N packet demultiplexer with a single registered output stage.
//
// One input stream uses a valid/ready handshake and is framed into packets by
// s_last. The first beat of each packet selects the destination channel
// through sel. Every later beat of that packet follows the same channel, and
// sel is ignored until the next packet begins. Each accepted beat goes into
// one hold register that drives all output channels. Only the addressed
// channel sees m_valid/m_last. A packet whose first-beat sel is out of range
// (sel >= N) is accepted and dropped in full.
//
// Parameters
//   DW  data width in bits
//   N   number of output channels (2..16)
//   SW  select width, 2**SW >= N
//
// Ports
//   clk      in   1     rising-edge clock
//   rst_n    in   1     asynchronous active-low reset
//   s_valid  in   1     input beat valid
//   s_ready  out  1     input beat accepted when s_valid & s_ready
//   s_data   in   DW    input data
//   s_last   in   1     final beat of the packet
//   sel      in   SW    destination channel, sampled on the first beat only
//   m_valid  out  N     one-hot per-channel valid
//   m_ready  in   N     per-channel ready
//   m_data   out  N*DW  held data, replicated into every channel slice
//   m_last   out  N     per-channel last, qualified by m_valid
//   busy     out  1     high between the first and the last beat of a packet
//   pkt_cnt  out  N*8   per-channel delivered-packet counters (8 bit, wrapping)
//
// Build option
//   DEMUX_PKT_CNT_EN  when defined, adds the pkt_cnt port and its counters.
//                     When undefined, both are absent and all other
//                     behaviour is unchanged.
// -----------------------------------------------------------------------------
module stream_demux #(
    parameter int DW = 8,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_data,
    input  logic            s_last,
    input  logic [SW-1:0]   sel,
    output logic [N-1:0]    m_valid,
    input  logic [N-1:0]    m_ready,
    output logic [N*DW-1:0] m_data,
    output logic [N-1:0]    m_last,
    output logic            busy
`ifdef DEMUX_PKT_CNT_EN
    ,
    output logic [N*8-1:0]  pkt_cnt
`endif
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ROUTE = 1'b1
    } state_t;

    // Channel count widened by one bit so that the range check on the
    // select value never truncates.
    localparam logic [SW:0] N_W = (SW+1)'(N);

    state_t          state;
    logic [SW-1:0]   ch_q;
    logic            busy_q;

    logic [SW-1:0]   eff_ch_p0;
    logic            ch_ok_p0;
    logic            accept_p0;
    logic            load_p0;

    logic            vld_p1;
    logic [DW-1:0]   data_p1;
    logic            last_p1;
    logic [SW-1:0]   ch_p1;
    logic            out_rdy_p1;
    logic            drain_p1;

    // ---- stage p0: input handshake and channel resolution ----
    // The first beat of a packet is routed by the live sel. Later beats use
    // the channel latched when the packet started.
    always_comb begin
        eff_ch_p0 = (state == ST_IDLE) ? sel : ch_q;
        ch_ok_p0  = ({1'b0, eff_ch_p0} < N_W);
    end

    // Ready of the channel that owns the held beat. Only that channel can
    // release the hold register, so other channels' readiness is ignored and
    // beats are never reordered.
    always_comb begin
        out_rdy_p1 = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (ch_p1 == SW'(k)) begin
                out_rdy_p1 = m_ready[k];
            end
        end
    end

    assign drain_p1  = vld_p1 & out_rdy_p1;
    assign s_ready   = ~vld_p1 | out_rdy_p1;
    assign accept_p0 = s_valid & s_ready;
    // Beats of a packet with an out-of-range channel are accepted but never
    // loaded, so the whole packet is dropped.
    assign load_p0   = accept_p0 & ch_ok_p0;

    // Packet framing FSM. It advances on every accepted beat, whether the
    // beat is delivered or dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ch_q   <= '0;
            busy_q <= 1'b0;
        end else if (accept_p0) begin
            case (state)
                ST_IDLE: begin
                    if (!s_last) begin
                        state  <= ST_ROUTE;
                        ch_q   <= sel;
                        busy_q <= 1'b1;
                    end
                end
                ST_ROUTE: begin
                    if (s_last) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

    // ---- stage p1: hold register driving the output channels ----
    // A load in the same cycle as a drain replaces the held beat directly,
    // so back-to-back beats (even to different channels) have no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            ch_p1   <= '0;
        end else if (load_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= s_data;
            last_p1 <= s_last;
            ch_p1   <= eff_ch_p0;
        end else if (drain_p1) begin
            vld_p1  <= 1'b0;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_out
        assign m_valid[k]          = vld_p1 & (ch_p1 == SW'(k));
        assign m_last[k]           = vld_p1 & last_p1 & (ch_p1 == SW'(k));
        assign m_data[k*DW +: DW]  = data_p1;
    end

`ifdef DEMUX_PKT_CNT_EN
    // A packet counts as delivered when its last beat leaves on that
    // channel. Dropped packets never reach the hold register, so they are
    // never counted.
    for (genvar k = 0; k < N; k++) begin : g_cnt
        logic [7:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= 8'd0;
            end else if (m_valid[k] & m_ready[k] & m_last[k]) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end

        assign pkt_cnt[k*8 +: 8] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

    logic        clk;
    logic        rst_n;

    // Four-channel instance
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [1:0]  sel;
    logic [3:0]  m_valid;
    logic [3:0]  m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_last;
    logic        busy;

    // Three-channel instance, used for out-of-range selects
    logic        s_valid3;
    logic        s_ready3;
    logic [7:0]  s_data3;
    logic        s_last3;
    logic [1:0]  sel3;
    logic [2:0]  m_valid3;
    logic [2:0]  m_ready3;
    logic [23:0] m_data3;
    logic [2:0]  m_last3;
    logic        busy3;

`ifdef DEMUX_PKT_CNT_EN
    logic [31:0] pkt_cnt;
    logic [23:0] pkt_cnt3;
`endif

    int vectors;
    int miscompares;

    stream_demux #(.DW(8), .N(4), .SW(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .sel     (sel),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .busy    (busy)
`ifdef DEMUX_PKT_CNT_EN
        ,
        .pkt_cnt (pkt_cnt)
`endif
    );

    stream_demux #(.DW(8), .N(3), .SW(2)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid3),
        .s_ready (s_ready3),
        .s_data  (s_data3),
        .s_last  (s_last3),
        .sel     (sel3),
        .m_valid (m_valid3),
        .m_ready (m_ready3),
        .m_data  (m_data3),
        .m_last  (m_last3),
        .busy    (busy3)
`ifdef DEMUX_PKT_CNT_EN
        ,
        .pkt_cnt (pkt_cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d, input logic l);
        s_valid = v;
        sel     = s;
        s_data  = d;
        s_last  = l;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        m_ready  = 4'hF;
        s_valid3 = 1'b0;
        s_data3  = 8'h00;
        s_last3  = 1'b0;
        sel3     = 2'd0;
        m_ready3 = 3'h7;

        // ---------------- reset ----------------
        #2;
        chk("rst_mvalid", 64'(m_valid), 64'h0);
        chk("rst_busy",   64'(busy),    64'h0);
        chk("rst_mdata",  64'(m_data),  64'h0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_sready", 64'(s_ready), 64'h1);
        chk("idle_mvalid", 64'(m_valid), 64'h0);
        chk("idle_mlast",  64'(m_last),  64'h0);
        chk("idle_busy",   64'(busy),    64'h0);
        chk("idle3_sready", 64'(s_ready3), 64'h1);
        tick();

        // ---------------- 3-beat packet to ch2 ----------------
        drive(1'b1, 2'd2, 8'hA1, 1'b0);
        tick();
        chk("p2_b1_mvalid", 64'(m_valid), 64'h4);
        chk("p2_b1_mdata",  64'(m_data),  64'hA1A1_A1A1);
        chk("p2_b1_mlast",  64'(m_last),  64'h0);
        chk("p2_b1_busy",   64'(busy),    64'h1);
        drive(1'b1, 2'd2, 8'hA2, 1'b0);
        tick();
        chk("p2_b2_mvalid", 64'(m_valid), 64'h4);
        chk("p2_b2_mdata",  64'(m_data[23:16]), 64'hA2);
        chk("p2_b2_busy",   64'(busy),    64'h1);
        drive(1'b1, 2'd2, 8'hA3, 1'b1);
        tick();
        chk("p2_b3_mvalid", 64'(m_valid), 64'h4);
        chk("p2_b3_mdata",  64'(m_data[23:16]), 64'hA3);
        chk("p2_b3_mlast",  64'(m_last),  64'h4);
        chk("p2_b3_busy",   64'(busy),    64'h0);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("p2_end_mvalid", 64'(m_valid), 64'h0);
`ifdef DEMUX_PKT_CNT_EN
        chk("p2_cnt", 64'(pkt_cnt), 64'h0001_0000);
`endif

        // ---------------- back-to-back single-beat packets ----------------
        drive(1'b1, 2'd0, 8'h11, 1'b1);
        tick();
        chk("b2b_0_mvalid", 64'(m_valid), 64'h1);
        chk("b2b_0_mdata",  64'(m_data[7:0]), 64'h11);
        chk("b2b_0_mlast",  64'(m_last),  64'h1);
        chk("b2b_0_busy",   64'(busy),    64'h0);
        drive(1'b1, 2'd3, 8'h33, 1'b1);
        tick();
        chk("b2b_3_mvalid", 64'(m_valid), 64'h8);
        chk("b2b_3_mdata",  64'(m_data[31:24]), 64'h33);
        chk("b2b_3_mlast",  64'(m_last),  64'h8);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("b2b_end_mvalid", 64'(m_valid), 64'h0);
`ifdef DEMUX_PKT_CNT_EN
        chk("b2b_cnt", 64'(pkt_cnt), 64'h0101_0001);
`endif

        // ---------------- stall on ch1 ----------------
        drive(1'b1, 2'd1, 8'h41, 1'b0);
        tick();
        chk("stl_b1_mvalid", 64'(m_valid), 64'h2);
        m_ready = 4'b1101;
        drive(1'b1, 2'd1, 8'h42, 1'b0);
        #1;
        chk("stl_sready_lo", 64'(s_ready), 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stl_hold_mvalid", 64'(m_valid), 64'h2);
            chk("stl_hold_mdata",  64'(m_data[15:8]), 64'h41);
            chk("stl_hold_sready", 64'(s_ready), 64'h0);
            chk("stl_hold_busy",   64'(busy),    64'h1);
        end
        m_ready = 4'hF;
        #1;
        chk("stl_sready_hi", 64'(s_ready), 64'h1);
        tick();
        chk("stl_b2_mvalid", 64'(m_valid), 64'h2);
        chk("stl_b2_mdata",  64'(m_data[15:8]), 64'h42);
        drive(1'b1, 2'd1, 8'h43, 1'b1);
        tick();
        chk("stl_b3_mdata", 64'(m_data[15:8]), 64'h43);
        chk("stl_b3_mlast", 64'(m_last), 64'h2);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("stl_end_mvalid", 64'(m_valid), 64'h0);

        // ---------------- sel change mid-packet ----------------
        drive(1'b1, 2'd1, 8'h51, 1'b0);
        tick();
        chk("selchg_b1_mvalid", 64'(m_valid), 64'h2);
        drive(1'b1, 2'd3, 8'h52, 1'b0);
        tick();
        chk("selchg_b2_mvalid", 64'(m_valid), 64'h2);
        chk("selchg_b2_mdata",  64'(m_data[15:8]), 64'h52);
        drive(1'b1, 2'd3, 8'h53, 1'b1);
        tick();
        chk("selchg_b3_mvalid", 64'(m_valid), 64'h2);
        chk("selchg_b3_mlast",  64'(m_last),  64'h2);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
`ifdef DEMUX_PKT_CNT_EN
        chk("selchg_cnt", 64'(pkt_cnt), 64'h0101_0201);
`endif

        // ---------------- asynchronous reset mid-packet ----------------
        drive(1'b1, 2'd2, 8'h77, 1'b0);
        tick();
        chk("arst_pre_mvalid", 64'(m_valid), 64'h4);
        chk("arst_pre_busy",   64'(busy),    64'h1);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_mvalid", 64'(m_valid), 64'h0);
        chk("arst_busy",   64'(busy),    64'h0);
        chk("arst_mdata",  64'(m_data),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_post_mvalid", 64'(m_valid), 64'h0);
        chk("arst_post_sready", 64'(s_ready), 64'h1);
`ifdef DEMUX_PKT_CNT_EN
        chk("arst_cnt", 64'(pkt_cnt), 64'h0);
`endif
        drive(1'b1, 2'd1, 8'h88, 1'b1);
        tick();
        chk("arst_new_mvalid", 64'(m_valid), 64'h2);
        chk("arst_new_busy",   64'(busy),    64'h0);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        tick();

        // ---------------- out-of-range select on the 3-channel instance ----------------
        s_valid3 = 1'b1;
        sel3     = 2'd3;
        s_data3  = 8'h99;
        s_last3  = 1'b0;
        #1;
        chk("inv_b1_sready", 64'(s_ready3), 64'h1);
        tick();
        chk("inv_b1_mvalid", 64'(m_valid3), 64'h0);
        chk("inv_b1_busy",   64'(busy3),    64'h1);
        sel3    = 2'd0;
        s_data3 = 8'h9A;
        s_last3 = 1'b1;
        #1;
        chk("inv_b2_sready", 64'(s_ready3), 64'h1);
        tick();
        chk("inv_b2_mvalid", 64'(m_valid3), 64'h0);
        chk("inv_b2_busy",   64'(busy3),    64'h0);
`ifdef DEMUX_PKT_CNT_EN
        chk("inv_cnt", 64'(pkt_cnt3), 64'h0);
`endif
        sel3    = 2'd2;
        s_data3 = 8'h9B;
        s_last3 = 1'b1;
        tick();
        chk("inv_next_mvalid", 64'(m_valid3), 64'h4);
        chk("inv_next_mdata",  64'(m_data3),  64'h9B9B9B);
        chk("inv_next_mlast",  64'(m_last3),  64'h4);
        s_valid3 = 1'b0;
        tick();
        chk("inv_end_mvalid", 64'(m_valid3), 64'h0);
`ifdef DEMUX_PKT_CNT_EN
        chk("inv_next_cnt", 64'(pkt_cnt3), 64'h01_0000);
`endif

        // ---------------- 256 single-beat packets to ch0 ----------------
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 2'd0, 8'(i), 1'b1);
            tick();
            chk("wrap_mvalid", 64'(m_valid), 64'h1);
`ifdef DEMUX_PKT_CNT_EN
            if (i == 255) chk("wrap_cnt_255", 64'(pkt_cnt[7:0]), 64'd255);
`endif
        end
        chk("wrap_last_mdata", 64'(m_data[7:0]), 64'hFF);
        drive(1'b0, 2'd0, 8'h00, 1'b0);
        tick();
        chk("wrap_end_mvalid", 64'(m_valid), 64'h0);
`ifdef DEMUX_PKT_CNT_EN
        chk("wrap_cnt", 64'(pkt_cnt), 64'h0000_0100);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
